adc_pattern_gen: RTL and testbench

Multi-channel ADC test-pattern source. It is the parametrised successor of the fixed 8-channel ROM playback generator. It streams NUM_CH parallel samples per beat over a valid/ready interface, with selectable pattern mode, programmable frame length, one-shot or looped operation, and frame markers. It feeds the FFT/BRAM capture path in place of the live ADC front end for bring-up and regression.

---
 rtl/adc_pattern_gen.sv | 190 +++++++++++++++++++
 tb/tb_adc_pattern_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_gen.sv
// adc_pattern_gen: NUM_CH-channel ADC test-pattern source that streams one
// multi-channel beat per cycle over a valid/ready port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              run control pulses
//   mode                     0=ROM, 1=ramp, 2=constant, 3=zero
//   loop_en                  repeat frames until stop
//   frame_len                beats per frame (0 or >DATA_DEPTH -> DATA_DEPTH)
//   const_val                constant-mode sample value
//   m_valid/m_ready/m_data   output beat handshake and payload
//   m_first/m_last           beat is frame index 0 / frame_len-1
//   busy, done, frame_cnt    status: running, end-of-run pulse, frames sent
// Channel ROM k holds word n = 0x100*k + n, the reference image of the
// <INIT_PREFIX><k>.mem files; an empty INIT_PREFIX gives a blank ROM.
module adc_pattern_gen #(
    parameter int    DATA_WIDTH  = 24,
    parameter int    NUM_CH      = 8,
    parameter int    DATA_DEPTH  = 512,
    parameter int    ROM_LATENCY = 2,
    parameter string INIT_PREFIX = "adc_ch",
    localparam int   ADDR_WIDTH  = $clog2(DATA_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic                         loop_en,
    input  logic [ADDR_WIDTH:0]          frame_len,
    input  logic [DATA_WIDTH-1:0]        const_val,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
    output logic                         m_first,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  frame_cnt
);

    localparam int BW = NUM_CH * DATA_WIDTH;
    localparam int L  = ROM_LATENCY;
    localparam int FD = ROM_LATENCY + 1;
    localparam int CW = $clog2(FD + 1);
    localparam int PW = $clog2(FD);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam bit ROM_BLANK = (INIT_PREFIX == "");

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q;
    logic                    loop_q;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [DATA_WIDTH-1:0]   const_q;
    logic [ADDR_WIDTH-1:0]   idx_q;

    logic [L-1:0]            pv, pf, pl;
    logic [BW-1:0]           pd [L];
    logic [BW+1:0]           fmem [FD];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           fcnt, in_flight;
    logic [CW:0]             occ;
    logic [BW-1:0]           word;
    logic                    go, issue, at_last, fempty, push, pop, hs;

    function automatic logic [DATA_WIDTH-1:0] rom_word(
        input int k, input logic [ADDR_WIDTH-1:0] n);
        if (ROM_BLANK) return '0;
        return DATA_WIDTH'(k * 256) + DATA_WIDTH'(n);
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_d = (frame_len == '0 || frame_len > DEPTH_W) ? DEPTH_W
                                                            : frame_len;
    assign go      = (state_q == IDLE) && start && !stop;
    assign at_last = ({1'b0, idx_q} == len_q - 1'b1);

    // Credit: every issued read owns a FIFO slot until it is delivered.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < L; i++) in_flight = in_flight + CW'(pv[i]);
    end
    assign occ   = {1'b0, in_flight} + {1'b0, fcnt};
    assign issue = (state_q == RUN) && (occ < (CW + 1)'(FD));

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode_q)
                2'd0: word[k*DATA_WIDTH +: DATA_WIDTH] = rom_word(k, idx_q);
                2'd1: word[k*DATA_WIDTH +: DATA_WIDTH] =
                          DATA_WIDTH'(idx_q) + DATA_WIDTH'(k);
                2'd2: word[k*DATA_WIDTH +: DATA_WIDTH] = const_q;
                default: ;
            endcase
        end
    end

    // Every mode rides the same delay line so latency is mode-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
            for (int i = 0; i < L; i++) pd[i] <= '0;
        end else begin
            pv[0] <= issue;
            pf[0] <= issue && (idx_q == '0);
            pl[0] <= issue && at_last;
            pd[0] <= word;
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // Skid FIFO; an empty FIFO lets the delay-line output straight through.
    assign fempty  = (fcnt == '0);
    assign m_valid = !fempty || pv[L-1];
    assign {m_first, m_last, m_data} =
        fempty ? {pf[L-1], pl[L-1], pd[L-1]} : fmem[rd_ptr];
    assign hs   = m_valid && m_ready;
    assign push = pv[L-1] && !(fempty && m_ready);
    assign pop  = !fempty && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fcnt   <= '0;
            for (int i = 0; i < FD; i++) fmem[i] <= '0;
        end else begin
            if (push) begin
                fmem[wr_ptr] <= {pf[L-1], pl[L-1], pd[L-1]};
                wr_ptr       <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) fcnt <= fcnt + 1'b1;
            else if (pop && !push) fcnt <= fcnt - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (go) state_d = RUN;
            RUN:   if (stop || (issue && at_last && !loop_q)) state_d = DRAIN;
            DRAIN: if (occ == '0 || (occ == (CW + 1)'(1) && hs))
                       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            mode_q    <= '0;
            loop_q    <= 1'b0;
            len_q     <= '0;
            const_q   <= '0;
            idx_q     <= '0;
            frame_cnt <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == DRAIN) && (state_d == IDLE);
            if (go) begin
                mode_q    <= mode;
                loop_q    <= loop_en;
                len_q     <= len_d;
                const_q   <= const_val;
                idx_q     <= '0;
                frame_cnt <= '0;
            end else begin
                if (issue) idx_q <= at_last ? '0 : idx_q + 1'b1;
                if (hs && m_last) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_adc_pattern_gen.sv
// tb_adc_pattern_gen: scoreboard bench for adc_pattern_gen.
// Expected beats are queued at run start; a negedge monitor pops and compares.
module tb_adc_pattern_gen;

    localparam int W     = 24;
    localparam int NCH   = 8;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;
    localparam int AW    = 9;

    logic clk = 1'b0;
    logic rst, start, stop, loop_en, m_ready;
    logic [1:0] mode;
    logic [AW:0] frame_len;
    logic [W-1:0] const_val;
    logic m_valid, m_first, m_last, busy, done;
    logic [NCH*W-1:0] m_data;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    adc_pattern_gen #(
        .DATA_WIDTH(W), .NUM_CH(NCH), .DATA_DEPTH(DEPTH),
        .ROM_LATENCY(LAT), .INIT_PREFIX("adc_ch")
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .loop_en(loop_en), .frame_len(frame_len), .const_val(const_val),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_first(m_first), .m_last(m_last), .busy(busy), .done(done),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [NCH*W-1:0] d;
        logic             f;
        logic             l;
    } beat_t;

    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Spec-level model: channel k, frame index n.
    function automatic logic [NCH*W-1:0] model(int md, int n, logic [W-1:0] cv);
        logic [NCH*W-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            case (md)
                0: r[k*W +: W] = W'(256 * k + n);
                1: r[k*W +: W] = W'(n + k);
                2: r[k*W +: W] = cv;
                default: r[k*W +: W] = '0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(string nm, longint act, longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // m_ready driver: 0 = always high, 1 = 1,0,0,1,0,1 pattern, 2 = random
    int rdy_mode = 0;
    int rcnt = 0;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: m_ready = pat[rcnt % 6];
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
        rcnt++;
    end

    bit    mon_en = 0;
    int    beats = 0;
    int    first_valid_cyc = -1;
    int    last_hs_cyc = -1;
    int    done_cyc = -1;
    bit    prev_stall = 0;
    beat_t prev_b;

    always @(negedge clk) begin
        beat_t cur, e;
        cur = {m_data, m_first, m_last};
        if (mon_en) begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || cur !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%h f=%0b l=%0b, expected v=1 d=%h f=%0b l=%0b",
                             m_valid, m_data, m_first, m_last,
                             prev_b.d, prev_b.f, prev_b.l);
                end
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got d=%h f=%0b l=%0b, expected no beat",
                             m_data, m_first, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat%0d: got d=%h f=%0b l=%0b, expected d=%h f=%0b l=%0b",
                                 beats, m_data, m_first, m_last, e.d, e.f, e.l);
                    end
                end
                beats++;
                last_hs_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            prev_stall = m_valid && !m_ready;
            prev_b = cur;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic clear_stats();
        beats = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        done_cyc = -1;
        mon_en = 1;
    endtask

    task automatic run_case(string nm, int md, bit lp, int len,
                            logic [W-1:0] cv, int rm, int stop_after,
                            bit disturb);
        int lf, s_cyc, bstop;
        bit got;
        beat_t b;
        lf = (len == 0 || len > DEPTH) ? DEPTH : len;
        bstop = 0;
        exp_q.delete();
        for (int i = 0; i < (lp ? 60 : lf); i++) begin
            b.d = model(md, i % lf, cv);
            b.f = (i % lf) == 0;
            b.l = (i % lf) == lf - 1;
            exp_q.push_back(b);
        end
        @(negedge clk);
        rdy_mode = rm;
        rcnt = 0;
        @(posedge clk); #1;
        mode = 2'(md); loop_en = lp; frame_len = (AW + 1)'(len);
        const_val = cv; start = 1; s_cyc = cyc;
        clear_stats();
        @(posedge clk); #1;
        start = 0;
        mode = 2'($urandom); loop_en = 1'($urandom);
        frame_len = (AW + 1)'($urandom); const_val = W'($urandom);
        if (disturb) begin
            repeat (3) @(posedge clk);
            #1; start = 1; mode = 2'd0; const_val = W'($urandom);
            @(posedge clk); #1; start = 0;
        end
        if (stop_after > 0) begin
            repeat (stop_after) @(posedge clk);
            #1; stop = 1;
            @(posedge clk);
            bstop = beats;
            #1; stop = 0;
        end
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        chk({nm, "_done_seen"}, got, 1);
        @(posedge clk); #1;
        chk({nm, "_busy_after"}, busy, 0);
        if (!lp) begin
            chk({nm, "_beats"}, beats, lf);
            chk({nm, "_frame_cnt"}, frame_cnt, 1);
        end else begin
            chk({nm, "_frame_cnt"}, frame_cnt, beats / lf);
        end
        if (stop_after > 0) begin
            chk({nm, "_post_stop_bound"}, (beats - bstop) <= LAT + 1, 1);
        end else begin
            chk({nm, "_first_latency"}, first_valid_cyc - s_cyc, LAT + 1);
            chk({nm, "_done_latency"}, done_cyc - last_hs_cyc, 1);
        end
        exp_q.delete();
    endtask

    task automatic reset_mid_run();
        exp_q.delete();
        for (int i = 0; i < 60; i++) begin
            beat_t b;
            b.d = model(1, i % 3, '0);
            b.f = (i % 3) == 0;
            b.l = (i % 3) == 2;
            exp_q.push_back(b);
        end
        @(negedge clk);
        rdy_mode = 0;
        @(posedge clk); #1;
        mode = 2'd1; loop_en = 1; frame_len = 3; start = 1;
        clear_stats();
        @(posedge clk); #1;
        start = 0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_valid_before", m_valid, 1);
        rst = 1;
        mon_en = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_data_zero", m_data == '0, 1);
        chk("rst_mid_frame_cnt", frame_cnt, 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; mode = 0; loop_en = 0;
        frame_len = 0; const_val = 0; m_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", m_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_data_zero", m_data == '0, 1);
        @(posedge clk); #1;
        rst = 0;

        // stop alone, and start together with stop, leave the block idle
        @(posedge clk); #1; stop = 1;
        @(posedge clk); #1; stop = 0;
        chk("idle_stop_ignored", busy, 0);
        start = 1; stop = 1;
        @(posedge clk); #1; start = 0; stop = 0;
        chk("start_with_stop_ignored", busy, 0);

        run_case("s1_rom", 0, 0, 4, '0, 0, 0, 0);
        run_case("s2_rom_stall", 0, 0, 4, '0, 1, 0, 0);
        run_case("s3_ramp_loop", 1, 1, 3, '0, 0, 10, 0);
        run_case("s3_ramp_loop_stall", 1, 1, 3, '0, 2, 15, 0);
        run_case("s4_len0", 0, 0, 0, '0, 0, 0, 0);
        run_case("s4_len_over", 0, 0, 700, '0, 2, 0, 0);
        run_case("s5_const", 2, 0, 20, 24'hABCDEF, 0, 0, 1);
        reset_mid_run();
        run_case("s6_after_rst", 0, 0, 4, '0, 0, 0, 0);
        run_case("len1", 0, 0, 1, '0, 2, 0, 0);
        run_case("len1_loop", 1, 1, 1, '0, 2, 8, 0);
        for (int r = 0; r < 6; r++) begin
            run_case($sformatf("rand%0d", r), $urandom_range(0, 3), 0,
                     $urandom_range(1, 20), W'($urandom), 2, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
